// File: rtl/rggen_axi4lite_responder.sv
// AXI4-Lite slave front end: serves one AXI4-Lite transaction at a time as a single rggen bus access.
// Optional feature macro: RGGEN_AXI4LITE_RESPONDER_READ_PRIORITY_EN (AR wins a simultaneous AW/W/AR request).
module rggen_axi4lite_responder #(
  parameter int ID_WIDTH      = 0,
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32,
  localparam int IW = (ID_WIDTH > 0) ? ID_WIDTH : 1,
  localparam int SW = BUS_WIDTH / 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [IW-1:0]            awid,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic [2:0]               awprot,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic [SW-1:0]            wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [IW-1:0]            bid,
  output logic [1:0]               bresp,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [IW-1:0]            arid,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [2:0]               arprot,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [IW-1:0]            rid,
  output logic [1:0]               rresp,
  output logic [BUS_WIDTH-1:0]     rdata,
  output logic                     bus_valid,
  output logic [1:0]               bus_access,
  output logic [ADDRESS_WIDTH-1:0] bus_address,
  output logic [BUS_WIDTH-1:0]     bus_write_data,
  output logic [SW-1:0]            bus_strobe,
  input  logic                     bus_ready,
  input  logic [1:0]               bus_status,
  input  logic [BUS_WIDTH-1:0]     bus_read_data
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] RESPONSE = 2'd2;

  localparam logic [1:0] RGGEN_READ  = 2'b00;
  localparam logic [1:0] RGGEN_WRITE = 2'b01;

  logic [1:0]           state;
  logic                 active;
  logic                 aw_done;
  logic                 w_done;
  logic [IW-1:0]        id;
  logic [1:0]           status;
  logic [BUS_WIDTH-1:0] read_data;

  logic idle;
  logic nothing_captured;
  logic read_grant;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic write_go;
  logic resp_hs;
  logic unused_prot;

  // active keeps every ready low while reset is held and for the first cycle after release
  assign idle             = active && (state == IDLE);
  assign nothing_captured = !(aw_done || w_done);

`ifdef RGGEN_AXI4LITE_RESPONDER_READ_PRIORITY_EN
  assign read_grant = idle && nothing_captured && arvalid;
`else
  assign read_grant = idle && nothing_captured && arvalid && !awvalid && !wvalid;
`endif

  assign awready = idle && !aw_done && !read_grant;
  assign wready  = idle && !w_done  && !read_grant;
  assign arready = read_grant;

  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid  && wready;
  assign ar_hs    = arvalid && arready;
  assign write_go = (aw_done || aw_hs) && (w_done || w_hs);
  assign resp_hs  = (bvalid && bready) || (rvalid && rready);

  assign bresp = status;
  assign rresp = status;
  assign rdata = read_data;
  assign bid   = (ID_WIDTH > 0) ? id : {IW{1'b0}};
  assign rid   = (ID_WIDTH > 0) ? id : {IW{1'b0}};

  assign unused_prot = ^{awprot, arprot};

  // Transaction sequencing, capture flags and the registered valid outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active     <= 1'b0;
      state      <= IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      bus_valid  <= 1'b0;
      bus_access <= RGGEN_READ;
      bvalid     <= 1'b0;
      rvalid     <= 1'b0;
    end else begin
      active <= 1'b1;
      case (state)
        IDLE: begin
          if (aw_hs) begin
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            w_done <= 1'b1;
          end
          if (ar_hs) begin
            bus_access <= RGGEN_READ;
            bus_valid  <= 1'b1;
            state      <= ACCESS;
          end else if (write_go) begin
            bus_access <= RGGEN_WRITE;
            bus_valid  <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            bvalid    <= (bus_access == RGGEN_WRITE);
            rvalid    <= (bus_access == RGGEN_READ);
            state     <= RESPONSE;
          end
        end
        RESPONSE: begin
          if (resp_hs) begin
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Request fields captured on AXI handshakes, result captured on the bus handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus_address    <= {ADDRESS_WIDTH{1'b0}};
      bus_write_data <= {BUS_WIDTH{1'b0}};
      bus_strobe     <= {SW{1'b0}};
      id             <= {IW{1'b0}};
      status         <= 2'b00;
      read_data      <= {BUS_WIDTH{1'b0}};
    end else begin
      if (aw_hs) begin
        bus_address <= awaddr;
        id          <= awid;
      end else if (ar_hs) begin
        bus_address <= araddr;
        id          <= arid;
      end
      if (w_hs) begin
        bus_write_data <= wdata;
        bus_strobe     <= wstrb;
      end else if (ar_hs) begin
        bus_strobe <= {SW{1'b1}};
      end
      if (bus_valid && bus_ready) begin
        status <= bus_status;
        if (bus_access == RGGEN_READ) begin
          read_data <= bus_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_rggen_axi4lite_responder.sv
// Directed bench for rggen_axi4lite_responder: transaction-level expectation queues checked every cycle.
module tb_rggen_axi4lite_responder;

  localparam int IDW = 4;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam logic [1:0] ACC_READ  = 2'b00;
  localparam logic [1:0] ACC_WRITE = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic           awvalid = 1'b0, awready;
  logic [IDW-1:0] awid = '0;
  logic [AW-1:0]  awaddr = '0;
  logic [2:0]     awprot = 3'b010;
  logic           wvalid = 1'b0, wready;
  logic [DW-1:0]  wdata = '0;
  logic [SW-1:0]  wstrb = '0;
  logic           bvalid, bready = 1'b0;
  logic [IDW-1:0] bid;
  logic [1:0]     bresp;
  logic           arvalid = 1'b0, arready;
  logic [IDW-1:0] arid = '0;
  logic [AW-1:0]  araddr = '0;
  logic [2:0]     arprot = 3'b001;
  logic           rvalid, rready = 1'b0;
  logic [IDW-1:0] rid;
  logic [1:0]     rresp;
  logic [DW-1:0]  rdata;
  logic           bus_valid;
  logic [1:0]     bus_access;
  logic [AW-1:0]  bus_address;
  logic [DW-1:0]  bus_write_data;
  logic [SW-1:0]  bus_strobe;
  logic           bus_ready = 1'b0;
  logic [1:0]     bus_status = 2'b00;
  logic [DW-1:0]  bus_read_data = '0;

  rggen_axi4lite_responder #(
    .ID_WIDTH(IDW), .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp), .rdata(rdata),
    .bus_valid(bus_valid), .bus_access(bus_access), .bus_address(bus_address),
    .bus_write_data(bus_write_data), .bus_strobe(bus_strobe), .bus_ready(bus_ready),
    .bus_status(bus_status), .bus_read_data(bus_read_data)
  );

  typedef struct {
    logic [1:0]    access;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            wait_cycles;
    logic [1:0]    status;
    logic [DW-1:0] rdata;
  } bus_t;

  typedef struct {
    bit             is_read;
    logic [1:0]     resp;
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } resp_t;

  bus_t  exp_bus[$];
  resp_t exp_resp[$];
  int n_cmp = 0;
  int n_bad = 0;
  int resp_delay = 0;

  int            obs_bus_start = 0, obs_bus_len = 0, obs_resp_start = 0, obs_resp_len = 0;
  logic [AW-1:0] obs_bus_addr = '0;
  logic [DW-1:0] obs_bus_data = '0, obs_rdata = '0;
  logic [SW-1:0] obs_bus_strb = '0;
  logic [1:0]    obs_resp_code = '0, obs_resp_kind = '0;
  logic [IDW-1:0] obs_resp_id = '0;

  initial begin
    forever begin
      #5 clk = 1'b1;
      cyc = cyc + 1;
      #5 clk = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a write becomes one write access and one B response carrying the bus status as bresp
  task automatic expect_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                              input logic [IDW-1:0] id, input int wt, input logic [1:0] st);
    exp_bus.push_back('{ACC_WRITE, addr, data, strb, wt, st, 32'h0});
    exp_resp.push_back('{1'b0, st, id, 32'h0});
  endtask

  task automatic expect_read(input logic [AW-1:0] addr, input logic [IDW-1:0] id, input int wt,
                             input logic [1:0] st, input logic [DW-1:0] data);
    exp_bus.push_back('{ACC_READ, addr, 32'h0, 4'hF, wt, st, data});
    exp_resp.push_back('{1'b1, st, id, data});
  endtask

  task automatic handshake(input int ch, input int dly, output int hs);
    bit ok;
    ok = 1'b0;
    hs = -1;
    repeat (dly) begin @(posedge clk); #1; end
    case (ch)
      0: awvalid = 1'b1;
      1: wvalid = 1'b1;
      default: arvalid = 1'b1;
    endcase
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      case (ch)
        0: ok = awready;
        1: ok = wready;
        default: ok = arready;
      endcase
      if (ok) hs = cyc;
      @(posedge clk); #1;
    end
    case (ch)
      0: awvalid = 1'b0;
      1: wvalid = 1'b0;
      default: arvalid = 1'b0;
    endcase
    check($sformatf("handshake_ch%0d", ch), 64'(ok), 64'd1);
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [IDW-1:0] id, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input int aw_dly, input int w_dly,
                           output int hs_aw, output int hs_w);
    int a, b;
    awaddr = addr; awid = id; wdata = data; wstrb = strb;
    fork
      handshake(0, aw_dly, a);
      handshake(1, w_dly, b);
    join
    hs_aw = a;
    hs_w  = b;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [IDW-1:0] id, input int dly, output int hs);
    araddr = addr; arid = id;
    handshake(2, dly, hs);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_resp.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(exp_bus.size() + exp_resp.size()), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // rggen bus slave: answers each access after the wait count the model holds for it
  initial begin : bus_slave
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n || !bus_valid || bus_ready) begin
        bus_ready = 1'b0;
        cnt = 0;
      end else if (exp_bus.size() != 0 && cnt >= exp_bus[0].wait_cycles) begin
        bus_ready     = 1'b1;
        bus_status    = exp_bus[0].status;
        bus_read_data = exp_bus[0].rdata;
      end else begin
        cnt++;
      end
    end
  end

  // B/R acceptor: raises bready/rready resp_delay cycles after the response appears
  initial begin : resp_driver
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (bvalid || rvalid) begin
        if (cnt >= resp_delay) begin
          bready = bvalid;
          rready = rvalid;
        end
        cnt++;
      end else begin
        bready = 1'b0;
        rready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the transaction queues
  initial begin : compare
    int    bus_cycles;
    bit    prev_bus_valid, prev_resp_pending, bus_hs;
    resp_t h;
    bus_t  b;
    bus_cycles = 0; prev_bus_valid = 1'b0; prev_resp_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus_cycles = 0; prev_bus_valid = 1'b0; prev_resp_pending = 1'b0;
        continue;
      end
      bus_hs = prev_bus_valid && bus_ready;
      check("b_r_exclusive", 64'(bvalid && rvalid), 64'd0);
      if (bus_valid || bvalid || rvalid) check("ready_when_busy", 64'({awready, wready, arready}), 64'd0);

      if (bus_valid) begin
        if (exp_bus.size() == 0) begin
          check("bus_spurious", 64'(bus_valid), 64'd0);
        end else begin
          b = exp_bus[0];
          check("bus_access", 64'(bus_access), 64'(b.access));
          check("bus_address", 64'(bus_address), 64'(b.addr));
          check("bus_strobe", 64'(bus_strobe), 64'(b.strb));
          if (b.access == ACC_WRITE) check("bus_write_data", 64'(bus_write_data), 64'(b.wdata));
        end
        bus_cycles++;
        if (bus_cycles == 1) begin
          obs_bus_start = cyc; obs_bus_addr = bus_address;
          obs_bus_data = bus_write_data; obs_bus_strb = bus_strobe;
        end
      end else if (prev_bus_valid) begin
        obs_bus_len = bus_cycles;
        if (exp_bus.size() != 0) begin
          check("bus_length", 64'(bus_cycles), 64'(exp_bus[0].wait_cycles + 1));
          void'(exp_bus.pop_front());
        end
        bus_cycles = 0;
      end

      if (prev_resp_pending) check("resp_hold", 64'(bvalid | rvalid), 64'd1);
      if (bvalid || rvalid) begin
        if (exp_resp.size() == 0) begin
          check("resp_spurious", 64'({bvalid, rvalid}), 64'd0);
        end else begin
          h = exp_resp[0];
          check("resp_kind", 64'({bvalid, rvalid}), h.is_read ? 64'd1 : 64'd2);
          if (rvalid) begin
            check("rresp", 64'(rresp), 64'(h.resp));
            check("rdata", 64'(rdata), 64'(h.data));
            check("rid", 64'(rid), 64'(h.id));
          end else begin
            check("bresp", 64'(bresp), 64'(h.resp));
            check("bid", 64'(bid), 64'(h.id));
          end
          if (!prev_resp_pending) begin
            check("resp_after_bus_ready", 64'(bus_hs), 64'd1);
            obs_resp_start = cyc; obs_resp_len = 0;
            obs_resp_kind = {bvalid, rvalid};
            obs_resp_code = rvalid ? rresp : bresp;
            obs_resp_id = rvalid ? rid : bid;
            obs_rdata = rdata;
          end
          obs_resp_len++;
          if ((bvalid && bready) || (rvalid && rready)) begin
            void'(exp_resp.pop_front());
            prev_resp_pending = 1'b0;
          end else begin
            prev_resp_pending = 1'b1;
          end
        end
      end else begin
        prev_resp_pending = 1'b0;
      end
      prev_bus_valid = bus_valid;
    end
  end

  initial begin : main
    int ha, hw, hr, h1, h2, dummy;
    #12;
    check("reset_handshakes", 64'({awready, wready, arready, bvalid, rvalid, bus_valid}), 64'd0);
    check("reset_fields", 64'({bresp, rresp, bid, rid, rdata}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Write, zero wait, AW and W together
    expect_write(16'h0010, 32'hA5A5_5A5A, 4'hF, 4'd1, 0, 2'd0);
    axi_write(16'h0010, 4'd1, 32'hA5A5_5A5A, 4'hF, 0, 0, ha, hw);
    wait_drain("t1_drain");
    check("t1_bus_len", 64'(obs_bus_len), 64'd1);
    check("t1_bus_addr", 64'(obs_bus_addr), 64'h10);
    check("t1_bus_data", 64'(obs_bus_data), 64'hA5A5_5A5A);
    check("t1_b_latency", 64'(obs_resp_start - ((ha > hw) ? ha : hw)), 64'd2);
    check("t1_bresp", 64'(obs_resp_code), 64'd0);

    // W leads AW by three cycles; bus access one cycle after the AW handshake
    expect_write(16'h0020, 32'h0000_BEEF, 4'h3, 4'd5, 1, 2'd1);
    axi_write(16'h0020, 4'd5, 32'h0000_BEEF, 4'h3, 3, 0, ha, hw);
    wait_drain("t2_drain");
    check("t2_w_before_aw", 64'(ha - hw), 64'd3);
    check("t2_bus_start", 64'(obs_bus_start - ha), 64'd1);
    check("t2_strobe", 64'(obs_bus_strb), 64'h3);
    check("t2_bid", 64'(obs_resp_id), 64'd5);
    check("t2_bresp", 64'(obs_resp_code), 64'd1);

    // Read with 4 wait cycles, SLVERR, rready delayed 3 cycles
    resp_delay = 3;
    expect_read(16'h0008, 4'd2, 4, 2'd2, 32'h1234_5678);
    axi_read(16'h0008, 4'd2, 0, hr);
    wait_drain("t3_drain");
    resp_delay = 0;
    check("t3_rdata", 64'(obs_rdata), 64'h1234_5678);
    check("t3_rresp", 64'(obs_resp_code), 64'd2);
    check("t3_rid", 64'(obs_resp_id), 64'd2);
    check("t3_rvalid_len", 64'(obs_resp_len), 64'd4);
    check("t3_bus_len", 64'(obs_bus_len), 64'd5);
    check("t3_strobe", 64'(obs_bus_strb), 64'hF);

    // Simultaneous AW/W/AR
`ifdef RGGEN_AXI4LITE_RESPONDER_READ_PRIORITY_EN
    expect_read(16'h0034, 4'd3, 0, 2'd0, 32'hCAFE_F00D);
    expect_write(16'h0030, 32'h0F0F_0F0F, 4'hF, 4'd7, 0, 2'd0);
`else
    expect_write(16'h0030, 32'h0F0F_0F0F, 4'hF, 4'd7, 0, 2'd0);
    expect_read(16'h0034, 4'd3, 0, 2'd0, 32'hCAFE_F00D);
`endif
    fork
      axi_write(16'h0030, 4'd7, 32'h0F0F_0F0F, 4'hF, 0, 0, ha, hw);
      axi_read(16'h0034, 4'd3, 0, hr);
    join
    wait_drain("t4_drain");
`ifdef RGGEN_AXI4LITE_RESPONDER_READ_PRIORITY_EN
    check("t4_read_first", 64'(ha - hr), 64'd3);
`else
    check("t4_write_first", 64'(hr - ha), 64'd3);
`endif

    // Back-to-back writes at peak rate: one acceptance every 3 cycles
    expect_write(16'h0040, 32'h0000_0001, 4'hF, 4'd8, 0, 2'd0);
    expect_write(16'h0044, 32'h0000_0002, 4'h1, 4'd9, 0, 2'd3);
    axi_write(16'h0040, 4'd8, 32'h0000_0001, 4'hF, 0, 0, h1, dummy);
    axi_write(16'h0044, 4'd9, 32'h0000_0002, 4'h1, 0, 0, h2, dummy);
    wait_drain("t6_drain");
    check("t6_turnaround", 64'(h2 - h1), 64'd3);
    check("t6_decerr", 64'(obs_resp_code), 64'd3);

    // Reset in the middle of a read access
    expect_read(16'h0050, 4'd4, 20, 2'd0, 32'hDEAD_0000);
    axi_read(16'h0050, 4'd4, 0, hr);
    repeat (2) begin @(posedge clk); #1; end
    check("t5_in_access", 64'(bus_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_handshakes", 64'({awready, wready, arready, bvalid, rvalid, bus_valid}), 64'd0);
    check("t5_rst_fields", 64'({bresp, rresp, bid, rid, rdata}), 64'd0);
    exp_bus.delete();
    exp_resp.delete();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    expect_write(16'h0060, 32'h1122_3344, 4'hC, 4'd6, 2, 2'd0);
    axi_write(16'h0060, 4'd6, 32'h1122_3344, 4'hC, 0, 0, ha, hw);
    wait_drain("t5_drain");
    repeat (10) begin @(posedge clk); #1; end
    check("t5_resp_kind", 64'(obs_resp_kind), 64'd2);
    check("t5_bid", 64'(obs_resp_id), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
